// File: rtl/exec_mc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// exec_mc_sequencer_pkg
// Shared definitions for the Execute-stage multi-cycle sequencer and the
// control unit: ALU opcode constants and the sequencer state enum.
// Optional feature macro used by the sequencer: MC_AV_EN (AV multi-cycle).
// ---------------------------------------------------------------------------
package exec_mc_sequencer_pkg;

  localparam int ALU_W = 4;

  localparam logic [ALU_W-1:0] ALU_NOP  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_MULT = 4'd3;
  localparam logic [ALU_W-1:0] ALU_AV   = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  // Counter preload for an op taking n Execute cycles. BUSY lasts n-2
  // cycles and leaves when the counter reads zero, so preload n-3.
  // n=2 never enters BUSY, so its preload is irrelevant and held at 0.
  function automatic logic [3:0] mc_preload(input int n);
    if (n >= 3) return 4'(n - 3);
    else        return 4'd0;
  endfunction

endpackage

// File: rtl/exec_mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// exec_mc_sequencer_if
// Bundles the hazard-unit / Execute-stage side of the multi-cycle sequencer.
//   master : hazard unit / pipeline (drives valid_e, alu_ctrl_e, flush_e,
//            stall_ext; consumes stalls, flush_m, unit controls, result_valid)
//   slave  : exec_mc_sequencer
// state and cycle_cnt are debug observation points of the sequencer FSM.
//
// Handshake: result_valid is a level. While it is high and stall_ext is low
// the multi-cycle result advances to Memory on the next rising edge; while
// stall_ext is high the result is held and result_valid stays high.
// ---------------------------------------------------------------------------
interface exec_mc_sequencer_if;
  import exec_mc_sequencer_pkg::*;

  logic                   valid_e;
  logic [ALU_W-1:0]       alu_ctrl_e;
  logic                   flush_e;
  logic                   stall_ext;

  logic                   stall_f;
  logic                   stall_d;
  logic                   stall_e;
  logic                   flush_m;
  logic                   unit_start;
  logic [ALU_W-1:0]       unit_op;
  logic                   result_valid;
  logic                   busy;

  mc_state_t              state;
  logic [3:0]             cycle_cnt;

  modport master (
    output valid_e, alu_ctrl_e, flush_e, stall_ext,
    input  stall_f, stall_d, stall_e, flush_m, unit_start, unit_op,
    input  result_valid, busy, state, cycle_cnt
  );

  modport slave (
    input  valid_e, alu_ctrl_e, flush_e, stall_ext,
    output stall_f, stall_d, stall_e, flush_m, unit_start, unit_op,
    output result_valid, busy, state, cycle_cnt
  );

endinterface

// File: rtl/exec_mc_sequencer_cycle_counter.sv
// ---------------------------------------------------------------------------
// mc_cycle_counter
// Loadable 4-bit down-counter that saturates at zero.
//   clk, reset : clock, synchronous active-high reset (clears to 0)
//   load       : load load_val (priority over en)
//   en         : decrement by one unless already zero
//   load_val   : preload value
//   count      : current value
//   zero       : count == 0
// ---------------------------------------------------------------------------
module mc_cycle_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/exec_mc_sequencer.sv
// ---------------------------------------------------------------------------
// exec_mc_sequencer
// Sequences multi-cycle ALU ops (MULT, and AV when MC_AV_EN is defined) in
// the Execute stage: pulses unit_start, stalls Fetch/Decode/Execute and
// bubbles Memory for N-1 cycles, then presents result_valid in DONE.
//   parameters : MULT_CYCLES (2..16), AV_CYCLES (2..16)
//   clk, reset : clock, synchronous active-high reset
//   bus        : exec_mc_sequencer_if.slave (inputs valid_e, alu_ctrl_e,
//                flush_e, stall_ext; outputs stall_f/d/e, flush_m,
//                unit_start, unit_op, result_valid, busy, debug state and
//                cycle_cnt)
// Configuration macro: MC_AV_EN -- when defined AV is multi-cycle using
// AV_CYCLES; otherwise AV executes in a single cycle like ADD.
// ---------------------------------------------------------------------------
module exec_mc_sequencer
  import exec_mc_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int AV_CYCLES   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  exec_mc_sequencer_if.slave   bus
);

`ifdef MC_AV_EN
  localparam bit AV_MC = 1'b1;
`else
  localparam bit AV_MC = 1'b0;
`endif

  localparam logic [3:0] MULT_LOAD = mc_preload(MULT_CYCLES);
  localparam logic [3:0] AV_LOAD   = mc_preload(AV_CYCLES);
  localparam bit         MULT_TWO  = (MULT_CYCLES == 2);
  localparam bit         AV_TWO    = (AV_CYCLES == 2);

  mc_state_t        state, state_n;
  logic [ALU_W-1:0] unit_op_q;
  logic             is_mult, is_av, is_mc, start;
  logic             stall_all, flush_m_c, unit_start_c, result_valid_c;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [3:0]       cnt_val, load_val;
  logic             two_cycle;

  assign is_mult   = (bus.alu_ctrl_e == ALU_MULT);
  assign is_av     = AV_MC && (bus.alu_ctrl_e == ALU_AV);
  assign is_mc     = is_mult || is_av;
  assign start     = (state == ST_IDLE) && bus.valid_e && !bus.flush_e && is_mc;
  assign load_val  = is_av ? AV_LOAD : MULT_LOAD;
  assign two_cycle = is_av ? AV_TWO : MULT_TWO;

  mc_cycle_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (load_val),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    stall_all      = 1'b0;
    flush_m_c      = 1'b0;
    unit_start_c   = 1'b0;
    result_valid_c = 1'b0;
    cnt_load       = 1'b0;
    cnt_en         = 1'b0;
    case (state)
      ST_IDLE: begin
        // Stalls in the start cycle come straight from the start condition.
        if (start) begin
          stall_all    = 1'b1;
          flush_m_c    = 1'b1;
          unit_start_c = 1'b1;
          cnt_load     = 1'b1;
          state_n      = two_cycle ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.flush_e) begin
          state_n = ST_IDLE;
        end else begin
          stall_all = 1'b1;
          flush_m_c = 1'b1;
          cnt_en    = 1'b1;
          if (cnt_zero) state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        // A kill wins over a downstream stall and drops the result.
        if (bus.flush_e) begin
          state_n = ST_IDLE;
        end else begin
          result_valid_c = 1'b1;
          if (bus.stall_ext) begin
            stall_all = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Reset silences every output in the reset cycle itself.
    if (reset) begin
      stall_all      = 1'b0;
      flush_m_c      = 1'b0;
      unit_start_c   = 1'b0;
      result_valid_c = 1'b0;
      cnt_load       = 1'b0;
      cnt_en         = 1'b0;
    end
  end

  // unit_op holds the started opcode for the whole operation and reads 0
  // whenever the sequencer is (or is returning to) IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      unit_op_q <= '0;
    end else if (unit_start_c) begin
      unit_op_q <= bus.alu_ctrl_e;
    end else if (state_n == ST_IDLE) begin
      unit_op_q <= '0;
    end
  end

  assign bus.stall_f      = stall_all;
  assign bus.stall_d      = stall_all;
  assign bus.stall_e      = stall_all;
  assign bus.flush_m      = flush_m_c;
  assign bus.unit_start   = unit_start_c;
  assign bus.unit_op      = reset ? '0 : unit_op_q;
  assign bus.result_valid = result_valid_c;
  assign bus.busy         = !reset && (state != ST_IDLE);
  assign bus.state        = state;
  assign bus.cycle_cnt    = cnt_val;

endmodule

// File: tb/tb_exec_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exec_mc_sequencer
// Drives exec_mc_sequencer (default parameters) with directed scenarios and
// random traffic. A reference model tracks each operation by its age in
// cycles and pushes the expected output vector per cycle into exp_q; a
// monitor on the falling edge pops and compares against the DUT.
// Honours MC_AV_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_exec_mc_sequencer;
  import exec_mc_sequencer_pkg::*;

  localparam int MULT_N = 4;
  localparam int AV_N   = 3;
  localparam int VW     = 11;

  logic clk;
  logic reset;

  exec_mc_sequencer_if bus ();

  exec_mc_sequencer #(
    .MULT_CYCLES (MULT_N),
    .AV_CYCLES   (AV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [VW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  // reference model: an operation is "active" from the cycle after start;
  // m_age counts cycles since start, DONE is reached at age n-1.
  bit         m_active = 1'b0;
  int         m_age    = 0;
  int         m_n      = 0;
  logic [3:0] m_op     = 4'd0;

  function automatic bit op_is_mc(input logic [3:0] op);
`ifdef MC_AV_EN
    return (op == ALU_MULT) || (op == ALU_AV);
`else
    return (op == ALU_MULT);
`endif
  endfunction

  function automatic logic [VW-1:0] pack(input bit stall, input bit fm,
                                         input bit us, input logic [3:0] op,
                                         input bit rv, input bit bz);
    return {stall, stall, stall, fm, us, op, rv, bz};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit v, input logic [3:0] op,
                       input bit fl, input bit sx);
    bit         e_stall, e_fm, e_us, e_rv, e_busy;
    logic [3:0] e_op;
    @(posedge clk);
    #1;
    reset          = r;
    bus.valid_e    = v;
    bus.alu_ctrl_e = op;
    bus.flush_e    = fl;
    bus.stall_ext  = sx;
    e_stall = 0; e_fm = 0; e_us = 0; e_rv = 0; e_busy = 0; e_op = 4'd0;
    if (r) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (v && !fl && op_is_mc(op)) begin
        e_stall  = 1; e_fm = 1; e_us = 1;
        m_n      = (op == ALU_MULT) ? MULT_N : AV_N;
        m_age    = 1;
        m_op     = op;
        m_active = 1'b1;
      end
    end else begin
      e_busy = 1;
      e_op   = m_op;
      if (fl) begin
        m_active = 1'b0;
      end else if (m_age < m_n - 1) begin
        e_stall = 1; e_fm = 1;
        m_age++;
      end else begin
        e_rv = 1;
        if (sx) e_stall = 1;
        else    m_active = 1'b0;
      end
    end
    exp_q.push_back(pack(e_stall, e_fm, e_us, e_op, e_rv, e_busy));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, ALU_NOP, 0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [VW-1:0] act, e;
    cyc++;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_m,
             bus.unit_start, bus.unit_op, bus.result_valid, bus.busy};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cycle=%0d {sf,sd,se,fm,us,op,rv,busy} got=%b want=%b",
                 cyc, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] op_tab [0:6];

  initial begin
    reset          = 1'b1;
    bus.valid_e    = 1'b0;
    bus.alu_ctrl_e = ALU_NOP;
    bus.flush_e    = 1'b0;
    bus.stall_ext  = 1'b0;
    op_tab[0] = ALU_NOP;  op_tab[1] = ALU_ADD; op_tab[2] = ALU_SUB;
    op_tab[3] = ALU_MULT; op_tab[4] = ALU_AV;  op_tab[5] = ALU_MULT;
    op_tab[6] = 4'hF;

    // reset state
    drive(1, 1, ALU_MULT, 0, 0);
    drive(1, 0, ALU_NOP, 0, 0);
    idle_cycles(2);

    // single MULT
    drive(0, 1, ALU_MULT, 0, 0);
    idle_cycles(5);

    // back-to-back MULTs: the instruction stays in Execute while stalled
    for (int i = 0; i < 9; i++) drive(0, 1, ALU_MULT, 0, 0);
    idle_cycles(3);

    // stall_ext held during t=3..5
    drive(0, 1, ALU_MULT, 0, 0);
    drive(0, 1, ALU_MULT, 0, 0);
    drive(0, 1, ALU_MULT, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, ALU_MULT, 0, 1);
    idle_cycles(3);

    // flush at t=2, and a flush during DONE with stall_ext also high
    drive(0, 1, ALU_MULT, 0, 0);
    drive(0, 1, ALU_MULT, 0, 0);
    drive(0, 1, ALU_MULT, 1, 0);
    idle_cycles(2);
    drive(0, 1, ALU_MULT, 0, 0);
    drive(0, 1, ALU_MULT, 0, 0);
    drive(0, 1, ALU_MULT, 0, 0);
    drive(0, 1, ALU_MULT, 1, 1);
    idle_cycles(2);

    // flush in the start cycle never starts
    drive(0, 1, ALU_MULT, 1, 0);
    drive(0, 0, ALU_MULT, 0, 0);
    idle_cycles(1);

    // AV
    drive(0, 1, ALU_AV, 0, 0);
    idle_cycles(4);

    // single-cycle ops
    drive(0, 1, ALU_ADD, 0, 0);
    drive(0, 1, ALU_SUB, 0, 1);
    drive(0, 1, 4'hF, 0, 0);

    // reset at t=1 of a MULT, then an ADD
    drive(0, 1, ALU_MULT, 0, 0);
    drive(1, 1, ALU_MULT, 0, 0);
    drive(0, 1, ALU_ADD, 0, 0);
    idle_cycles(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) != 0),
            op_tab[$urandom_range(0, 6)],
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0));
    end
    idle_cycles(4);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
